// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap option and a
// saturating match counter; registered one-cycle match pulse.
module seq_detector_param #(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          DEF_LEN = 4,
    parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(8'b0000_1011),
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8,
    localparam int unsigned         LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LW-1:0]      len_in,
    input  logic               clear,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LW-1:0]      len_q
);

    typedef enum logic {
        FILLING,
        ARMED
    } state_t;

    state_t state, state_nx;

    // Only MAX_LEN-1 past bits are stored; the current bit completes the window.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] hist_nx;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill;
    logic [LW-1:0]      fill_sat;
    logic [LW-1:0]      len_nx;
    logic               last_fill;
    logic               match;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
    end

    always_comb begin
        hist_nx   = {hist, in};
        last_fill = ((LW+1)'(fill) + (LW+1)'(1)) == (LW+1)'(len_q);
        match     = en && !load && ((state == ARMED) || last_fill)
                    && ((hist_nx & mask) == (pat & mask));
        fill_sat  = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;

        len_nx = len_in;
        if (len_in == '0) begin
            len_nx = LW'(1);
        end else if (len_in > LW'(MAX_LEN)) begin
            len_nx = LW'(MAX_LEN);
        end
    end

    always_comb begin
        state_nx = state;
        if (load) begin
            state_nx = FILLING;
        end else if (en) begin
            if (match && !OVERLAP) begin
                state_nx = FILLING;
            end else if ((state == FILLING) && last_fill) begin
                state_nx = ARMED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILLING;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= DEF_PAT;
            len_q     <= LW'(DEF_LEN);
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            out <= match;
            if (load) begin
                pat   <= pat_in;
                len_q <= len_nx;
                hist  <= '0;
                fill  <= '0;
            end else if (en) begin
                hist <= hist_nx[MAX_LEN-2:0];
                fill <= (match && !OVERLAP) ? '0 : fill_sat;
            end

            if (clear) begin
                match_cnt <= '0;
            end else if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: overlapping, non-overlapping and 2-bit-counter
// builds share one stimulus stream and are checked against a queue-based model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       d_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pat_in = '0;
    logic [3:0] len_in = '0;
    logic       clear = 1'b0;

    logic       o_out [3];
    logic [7:0] o_cnt [3];
    logic [3:0] o_len [3];
    logic [1:0] cnt_sat;

    assign o_cnt[2] = {6'b0, cnt_sat};

    always #5 clk = ~clk;

    seq_detector_param #(.OVERLAP(1'b1)) u_ov (
        .clk(clk), .rst(rst), .en(en), .in(d_in), .load(load), .pat_in(pat_in),
        .len_in(len_in), .clear(clear), .out(o_out[0]), .match_cnt(o_cnt[0]), .len_q(o_len[0])
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .in(d_in), .load(load), .pat_in(pat_in),
        .len_in(len_in), .clear(clear), .out(o_out[1]), .match_cnt(o_cnt[1]), .len_q(o_len[1])
    );

    seq_detector_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .in(d_in), .load(load), .pat_in(pat_in),
        .len_in(len_in), .clear(clear), .out(o_out[2]), .match_cnt(cnt_sat), .len_q(o_len[2])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: all bits sampled since reset/load, plus per-build start index.
    bit       s [$];
    int       st [3];
    int       m_cnt [3];
    bit       m_out [3];
    logic [7:0] m_pat;
    int       m_len;
    int       ov_of [3]  = '{1, 0, 1};
    int       cmax  [3]  = '{255, 255, 3};

    task automatic model_reset();
        s.delete();
        m_pat = 8'b0000_1011;
        m_len = 4;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0; m_cnt[i] = 0; m_out[i] = 1'b0;
        end
    endtask

    task automatic step(input bit e, input bit b, input bit ld = 1'b0,
                        input logic [7:0] p = 8'h00, input logic [3:0] l = 4'd0,
                        input bit clr = 1'b0);
        bit ok;
        en = e; d_in = b; load = ld; pat_in = p; len_in = l; clear = clr;
        @(posedge clk);
        if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((int'(l) > 8) ? 8 : int'(l));
            s.delete();
            for (int i = 0; i < 3; i++) begin st[i] = 0; m_out[i] = 1'b0; end
        end else if (e) begin
            s.push_back(b);
            for (int i = 0; i < 3; i++) begin
                ok = (s.size() - st[i]) >= m_len;
                for (int k = 0; k < m_len; k++) begin
                    if (ok && (s[s.size() - 1 - k] != m_pat[k])) ok = 1'b0;
                end
                m_out[i] = ok;
                if (ok && ov_of[i] == 0) st[i] = s.size();
            end
        end else begin
            for (int i = 0; i < 3; i++) m_out[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (m_out[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
        #1;
        en = 1'b0; load = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0; load = 1'b0; clear = 1'b0;
        rst = 1'b1;
        #3;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit seq [4] = '{1, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_out[i] !== 1'b0 || o_cnt[i] !== 8'd0 || o_len[i] !== 4'd4) begin
                bad++;
                $display("FAIL reset_state[%0d] got out=%b cnt=%0d len=%0d exp out=0 cnt=0 len=4",
                         i, o_out[i], o_cnt[i], o_len[i]);
            end
        end
        foreach (seq[j]) step(1'b1, seq[j]);
        total++;
        if (o_out[0] !== 1'b1) begin
            bad++; $display("FAIL pre_async_pulse got=%b exp=1", o_out[0]);
        end
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_out[i] !== 1'b0 || o_cnt[i] !== 8'd0) begin
                bad++;
                $display("FAIL async_reset[%0d] got out=%b cnt=%0d exp out=0 cnt=0", i, o_out[i], o_cnt[i]);
            end
        end
        rst = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_out[i] !== 1'b0 || o_out[i] !== m_out[i]) begin
                bad++; $display("FAIL midstream_reset[%0d] got=%b exp=0", i, o_out[i]);
            end
        end
    endtask

    task automatic test_default_stream();
        bit seq [11] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        do_reset();
        foreach (seq[j]) begin
            step(1'b1, seq[j]);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (o_out[i] !== m_out[i] || o_cnt[i] !== 8'(m_cnt[i])) begin
                    bad++;
                    $display("FAIL stream bit%0d[%0d] got out=%b cnt=%0d exp out=%b cnt=%0d",
                             j, i, o_out[i], o_cnt[i], m_out[i], m_cnt[i]);
                end
            end
            if (j == 6) begin
                total++;
                if (o_cnt[0] !== 8'd2 || o_cnt[1] !== 8'd1) begin
                    bad++;
                    $display("FAIL stream_counts got ov=%0d nov=%0d exp ov=2 nov=1", o_cnt[0], o_cnt[1]);
                end
            end
        end
        total++;
        if (o_cnt[1] !== 8'd2 || o_out[1] !== 1'b1) begin
            bad++; $display("FAIL nov_second got cnt=%0d out=%b exp cnt=2 out=1", o_cnt[1], o_out[1]);
        end
    endtask

    task automatic test_en_gaps();
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, g[0]);
            total++;
            if (o_out[0] !== 1'b0 || o_out[1] !== 1'b0) begin
                bad++; $display("FAIL en_gap%0d got ov=%b nov=%b exp 0", g, o_out[0], o_out[1]);
            end
        end
        step(1'b1, 1'b1);
        total++;
        if (o_out[0] !== 1'b0) begin
            bad++; $display("FAIL en_gap_early got=%b exp=0", o_out[0]);
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_out[i] !== 1'b1 || o_out[i] !== m_out[i]) begin
                bad++; $display("FAIL en_gap_match[%0d] got=%b exp=1", i, o_out[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] p = 8'b1110_0101;
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, p, 4'd8);
        total++;
        if (o_len[0] !== 4'd8 || o_out[0] !== 1'b0) begin
            bad++; $display("FAIL load_len got len=%0d out=%b exp len=8 out=0", o_len[0], o_out[0]);
        end
        // Seven bits that would complete the pattern only if the load-cycle sample leaked in.
        for (int b = 6; b >= 0; b--) begin
            step(1'b1, p[b]);
            total++;
            if (o_out[0] !== 1'b0 || o_out[0] !== m_out[0]) begin
                bad++; $display("FAIL load_drop bit%0d got=%b exp=0", b, o_out[0]);
            end
        end
        step(1'b1, 1'b0, 1'b1, p, 4'd8);
        for (int b = 7; b >= 0; b--) begin
            step(1'b1, p[b]);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (o_out[i] !== m_out[i] || o_out[i] !== (b == 0)) begin
                    bad++; $display("FAIL load_match bit%0d[%0d] got=%b exp=%b", b, i, o_out[i], m_out[i]);
                end
            end
        end
    endtask

    task automatic test_len1_sat();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'h01, 4'd0);
        total++;
        if (o_len[2] !== 4'd1) begin
            bad++; $display("FAIL len_clamp_lo got=%0d exp=1", o_len[2]);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b1);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (o_out[i] !== 1'b1 || o_cnt[i] !== 8'(m_cnt[i])) begin
                    bad++; $display("FAIL len1 c%0d[%0d] got out=%b cnt=%0d exp out=1 cnt=%0d",
                                    c, i, o_out[i], o_cnt[i], m_cnt[i]);
                end
            end
        end
        total++;
        if (o_cnt[2] !== 8'd3 || o_cnt[0] !== 8'd6 || o_cnt[1] !== 8'd6) begin
            bad++; $display("FAIL saturate got sat=%0d ov=%0d nov=%0d exp 3 6 6", o_cnt[2], o_cnt[0], o_cnt[1]);
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_out[i] !== 1'b1 || o_cnt[i] !== 8'd0) begin
                bad++; $display("FAIL clear_match[%0d] got out=%b cnt=%0d exp out=1 cnt=0", i, o_out[i], o_cnt[i]);
            end
        end
        step(1'b0, 1'b0, 1'b1, 8'hFF, 4'd15);
        total++;
        if (o_len[0] !== 4'd8) begin
            bad++; $display("FAIL len_clamp_hi got=%0d exp=8", o_len[0]);
        end
    endtask

    task automatic test_random();
        bit e, b, ld, clr;
        logic [7:0] p;
        logic [3:0] l;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            e   = ($urandom % 4) != 0;
            b   = 1'($urandom);
            ld  = ($urandom % 40) == 0;
            clr = ($urandom % 30) == 0;
            p   = 8'($urandom);
            l   = (($urandom % 8) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            step(e, b, ld, p, l, clr);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (o_out[i] !== m_out[i] || o_cnt[i] !== 8'(m_cnt[i]) || o_len[i] !== 4'(m_len)) begin
                    bad++;
                    $display("FAIL random c%0d[%0d] got out=%b cnt=%0d len=%0d exp out=%b cnt=%0d len=%0d",
                             c, i, o_out[i], o_cnt[i], o_len[i], m_out[i], m_cnt[i], m_len);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_en_gaps();
        test_load();
        test_len1_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
